// File: rtl/lc3_mem_arbiter.sv
// Round-robin arbiter sharing the single-port LC-3 main memory between the
// CPU memory interface and a DMA/console requester, with fixed access latency.
module lc3_mem_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_r,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_r,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        grant
);

  localparam int unsigned DW    = 16;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic [DW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             last_owner_q, last_owner_d;

  logic [DW-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]    dma_rdata_q, dma_rdata_d;
  logic             cpu_r_q, cpu_r_d;
  logic             dma_r_q, dma_r_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [DW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic             busy_q, busy_d;
  logic             grant_q, grant_d;

  logic             pick_dma;
  logic             in_access_d;

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_owner_q <= OWN_DMA;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_r_q      <= 1'b0;
      dma_r_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_owner_q <= last_owner_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_r_q      <= cpu_r_d;
      dma_r_q      <= dma_r_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
    end
  end

  // Next-state logic: arbitration in IDLE, countdown in ACCESS, one RESP cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_owner_d = last_owner_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_r_d      = 1'b0;
    dma_r_d      = 1'b0;
    pick_dma     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          // On a tie the requester that did not own the last access wins.
          pick_dma = dma_req && (!cpu_req || (last_owner_q == OWN_CPU));
          owner_d  = pick_dma ? OWN_DMA : OWN_CPU;
          we_d     = pick_dma ? dma_we    : cpu_we;
          addr_d   = pick_dma ? dma_addr  : cpu_addr;
          wdata_d  = pick_dma ? dma_wdata : cpu_wdata;
          cnt_d    = CNT_W'(MEM_LAT - 1);
          state_d  = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (owner_q == OWN_DMA) dma_rdata_d = mem_rdata;
            else                    cpu_rdata_d = mem_rdata;
          end
          // Ready flops load here so the pulse lines up with the RESP cycle.
          cpu_r_d      = (owner_q == OWN_CPU);
          dma_r_d      = (owner_q == OWN_DMA);
          last_owner_d = owner_q;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory-side and status outputs are registered from the next-state values.
  always_comb begin
    in_access_d = (state_d == S_ACCESS);
    mem_en_d    = in_access_d;
    mem_we_d    = in_access_d && we_d && (cnt_d == '0);
    mem_addr_d  = in_access_d ? addr_d  : '0;
    mem_wdata_d = in_access_d ? wdata_d : '0;
    busy_d      = (state_d != S_IDLE);
    grant_d     = busy_d ? owner_d : 1'b0;
  end

  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_r     = cpu_r_q;
  assign dma_r     = dma_r_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed self-checking bench for lc3_mem_arbiter with MEM_LAT = 2 and a
// simple combinational memory model.
module tb_lc3_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_r;
  logic        dma_req, dma_we;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_r;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, grant;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int dma_r_cnt = 0;

  lc3_mem_arbiter #(.MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_r(cpu_r),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_r(dma_r),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 16'h3000 holds 16'h1234, every other word reads addr ^ 16'hA5A5.
  always_comb mem_rdata = (mem_addr == 16'h3000) ? 16'h1234 : (mem_addr ^ 16'hA5A5);

  always @(posedge clk) begin
    if (mem_we) we_cnt++;
    if (dma_r)  dma_r_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    n_checks++; if ({cpu_r, dma_r, mem_we, grant} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want 0000", {cpu_r, dma_r, mem_we, grant}); end
    n_checks++; if ({cpu_rdata, dma_rdata, mem_addr} !== 48'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {cpu_rdata, dma_rdata, mem_addr}); end
    rst = 1'b0;
    tick();
  endtask

  // Tie right after reset: CPU first (cpu_r at t+3), then DMA (dma_r at t+7).
  task automatic test_reset_priority_tie();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0010;
    tick(); // t+1
    n_checks++; if (grant !== 1'b0) begin n_fail++; $display("FAIL tie_grant_cpu: got %b want 0", grant); end
    n_checks++; if (busy !== 1'b1)  begin n_fail++; $display("FAIL tie_busy: got %b want 1", busy); end
    tick(); // t+2
    n_checks++; if (cpu_r !== 1'b0) begin n_fail++; $display("FAIL tie_cpu_r_early: got %b want 0", cpu_r); end
    tick(); // t+3
    n_checks++; if (cpu_r !== 1'b1) begin n_fail++; $display("FAIL tie_cpu_r_t3: got %b want 1", cpu_r); end
    n_checks++; if (cpu_rdata !== (16'h0020 ^ 16'hA5A5)) begin n_fail++; $display("FAIL tie_cpu_rdata: got %h want %h", cpu_rdata, 16'h0020 ^ 16'hA5A5); end
    cpu_req = 0;
    tick(); // t+4 IDLE
    n_checks++; if (cpu_r !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL tie_idle: got r=%b busy=%b want 0 0", cpu_r, busy); end
    tick(); // t+5
    n_checks++; if (grant !== 1'b1) begin n_fail++; $display("FAIL tie_grant_dma: got %b want 1", grant); end
    tick(); // t+6
    n_checks++; if (dma_r !== 1'b0) begin n_fail++; $display("FAIL tie_dma_r_early: got %b want 0", dma_r); end
    tick(); // t+7
    n_checks++; if (dma_r !== 1'b1) begin n_fail++; $display("FAIL tie_dma_r_t7: got %b want 1", dma_r); end
    n_checks++; if (dma_rdata !== 16'hA5B5) begin n_fail++; $display("FAIL tie_dma_rdata: got %h want a5b5", dma_rdata); end
    dma_req = 0;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h3000) begin n_fail++; $display("FAIL rd_access%0d: got en=%b we=%b addr=%h want 1 0 3000", i, mem_en, mem_we, mem_addr); end
    end
    tick();
    n_checks++; if (cpu_r !== 1'b1 || cpu_rdata !== 16'h1234) begin n_fail++; $display("FAIL rd_resp: got r=%b data=%h want 1 1234", cpu_r, cpu_rdata); end
    n_checks++; if (dma_rdata !== 16'hA5B5) begin n_fail++; $display("FAIL rd_dma_rdata_kept: got %h want a5b5", dma_rdata); end
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rd_en_resp: got %b want 0", mem_en); end
    cpu_req = 0;
    tick();
  endtask

  task automatic test_dma_write();
    int w0, p0;
    w0 = we_cnt; p0 = dma_r_cnt;
    dma_req = 1; dma_we = 1; dma_addr = 16'h00FF; dma_wdata = 16'hBEEF;
    tick();
    n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_cycle1: got en=%b we=%b want 1 0", mem_en, mem_we); end
    tick();
    n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 16'hBEEF || mem_addr !== 16'h00FF) begin n_fail++; $display("FAIL wr_cycle2: got we=%b wdata=%h addr=%h want 1 beef 00ff", mem_we, mem_wdata, mem_addr); end
    tick();
    n_checks++; if (dma_r !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_resp: got r=%b we=%b want 1 0", dma_r, mem_we); end
    n_checks++; if (cpu_rdata !== 16'h1234 || dma_rdata !== 16'hA5B5) begin n_fail++; $display("FAIL wr_rdata_kept: got cpu=%h dma=%h want 1234 a5b5", cpu_rdata, dma_rdata); end
    dma_req = 0; dma_we = 0;
    tick(); tick();
    n_checks++; if (we_cnt - w0 !== 1) begin n_fail++; $display("FAIL wr_strobe_count: got %0d want 1", we_cnt - w0); end
    n_checks++; if (dma_r_cnt - p0 !== 1) begin n_fail++; $display("FAIL wr_r_count: got %0d want 1", dma_r_cnt - p0); end
  endtask

  // Both held high: last owner was DMA, so grants alternate starting with CPU.
  task automatic test_round_robin();
    logic [5:0] seen;
    logic [5:0] want;
    want = 6'b101010; // index 0 is the first access
    seen = '0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0001;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0002;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen[k] = grant;
      tick(); tick();
      n_checks++; if ({dma_r, cpu_r} !== (grant ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_r%0d: got dma_r=%b cpu_r=%b grant=%b", k, dma_r, cpu_r, grant); end
      if (k == 5) begin cpu_req = 0; dma_req = 0; end
      tick();
    end
    n_checks++; if (seen !== want) begin n_fail++; $display("FAIL rr_sequence: got %b want %b (bit0 first)", seen, want); end
  endtask

  task automatic test_input_change();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
    tick();
    cpu_addr = 16'h4000; cpu_req = 0;
    n_checks++; if (mem_addr !== 16'h3000 || grant !== 1'b0) begin n_fail++; $display("FAIL chg_a1: got addr=%h grant=%b want 3000 0", mem_addr, grant); end
    tick();
    n_checks++; if (mem_addr !== 16'h3000) begin n_fail++; $display("FAIL chg_a2: got %h want 3000", mem_addr); end
    tick();
    n_checks++; if (cpu_r !== 1'b1 || cpu_rdata !== 16'h1234) begin n_fail++; $display("FAIL chg_resp: got r=%b data=%h want 1 1234", cpu_r, cpu_rdata); end
    tick();
  endtask

  task automatic test_async_reset();
    int w0, p0;
    w0 = we_cnt; p0 = dma_r_cnt;
    dma_req = 1; dma_we = 1; dma_addr = 16'h0ABC; dma_wdata = 16'h5555;
    tick();
    n_checks++; if (grant !== 1'b1 || mem_en !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got grant=%b en=%b want 1 1", grant, mem_en); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({mem_en, mem_we, busy, grant} !== 4'b0) begin n_fail++; $display("FAIL ar_async_drop: got en,we,busy,grant=%b want 0000", {mem_en, mem_we, busy, grant}); end
    dma_req = 0; dma_we = 0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (we_cnt - w0 !== 0 || dma_r_cnt - p0 !== 0) begin n_fail++; $display("FAIL ar_no_resp: got we=%0d r=%0d want 0 0", we_cnt - w0, dma_r_cnt - p0); end
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0010;
    tick();
    n_checks++; if (grant !== 1'b0) begin n_fail++; $display("FAIL ar_tie_grant: got %b want 0", grant); end
    tick(); tick();
    n_checks++; if (cpu_r !== 1'b1) begin n_fail++; $display("FAIL ar_tie_cpu_r: got %b want 1", cpu_r); end
    cpu_req = 0; dma_req = 0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_reset_priority_tie();
    test_cpu_read();
    test_dma_write();
    test_round_robin();
    test_input_change();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Shares the single-port LC-3 main memory between two requesters: the CPU datapath memory interface (MAR/MDR with MIO_EN, R_W and R) and a DMA/console requester.
- Runs each granted access for a fixed multi-cycle latency and returns read data with a one-cycle ready pulse, which is the CPU's R input.
- Sits between the datapath memory interface and the memory array.

Parameters:
- MEM_LAT, 2: memory access length in cycles, legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cpu_req  in  1  CPU access request (MIO_EN); level, held until cpu_r.
- cpu_we  in  1  CPU write enable (R_W); 1 = write.
- cpu_addr  in  16  CPU address (MAR).
- cpu_wdata  in  16  CPU write data (MDR).
- cpu_rdata  out  16  CPU read data; registered.
- cpu_r  out  1  CPU ready; one-cycle pulse.
- dma_req  in  1  DMA request; level.
- dma_we  in  1  DMA write enable.
- dma_addr  in  16  DMA address.
- dma_wdata  in  16  DMA write data.
- dma_rdata  out  16  DMA read data; registered.
- dma_r  out  1  DMA ready; one-cycle pulse.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write strobe.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data; valid in the final ACCESS cycle.
- busy  out  1  an access is in progress.
- grant  out  1  owner of the current access; 0 = CPU, 1 = DMA.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - rst forces, immediately and regardless of clk, state = IDLE, all outputs 0, last_owner = DMA.
  - Consequence: the first tie after reset goes to the CPU.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Requests are sampled in IDLE only.
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester that is not last_owner (round-robin).
  - On the granting edge: latch owner, we, addr and wdata into internal registers; load cnt = MEM_LAT-1; go to ACCESS.
- ACCESS:
  - mem_en = 1.
  - mem_addr and mem_wdata come from the latched registers, so they are stable for the whole access even if requester inputs change.
  - mem_we = latched we AND (cnt == 0). A write is strobed exactly once, in the final cycle.
  - cnt decrements each cycle.
  - When cnt == 0: on a read, capture mem_rdata into the owner's rdata register; then go to RESP.
- RESP:
  - Pulse the owner's r for exactly one cycle.
  - last_owner <= owner.
  - Go to IDLE; requests are ignored during RESP.
- busy = 1 in ACCESS and RESP.
- grant holds the latched owner in ACCESS/RESP; it is 0 in IDLE.
- Latency: request high in IDLE at cycle t -> r high at cycle t+MEM_LAT+1.
  - Back-to-back throughput: one access per MEM_LAT+2 cycles.
- Requester rules:
  - A requester must deassert req in the cycle after its r pulse.
  - A req still high in the following IDLE cycle is treated as a new access.
- rdata registers:
  - Updated only by a completed read for that requester.
  - Writes and the other requester's accesses leave them unchanged.
- Request withdrawn mid-ACCESS: the access still completes, including the write strobe and r pulse. No abort.
- Request rising during ACCESS/RESP: it waits; it is arbitrated in the next IDLE cycle.
- rst asserted mid-ACCESS:
  - Access is abandoned, mem_en and mem_we drop immediately, no r pulse is issued.
  - The CPU controller's own reset restarts it.
- MEM_LAT = 1: a single ACCESS cycle with mem_we (if a write) and rdata capture in that same cycle.

Test Plan:
1. Reset priority tie:
   - Stimulus: MEM_LAT=2; rst pulse; then cpu_req=1 and dma_req=1 together in the same IDLE cycle.
   - Required: grant=0, CPU served first, cpu_r at t+3, then DMA served next, dma_r at t+7.
2. CPU read:
   - Stimulus: cpu_addr=16'h3000, mem model returns 16'h1234.
   - Required: mem_en high 2 cycles with mem_addr=16'h3000, mem_we=0; cpu_rdata=16'h1234 while cpu_r=1; dma_rdata unchanged.
3. DMA write:
   - Stimulus: dma_we=1, dma_addr=16'h00FF, dma_wdata=16'hBEEF.
   - Required: mem_we high only in the 2nd ACCESS cycle with mem_wdata=16'hBEEF; dma_r pulses once; cpu_rdata unchanged.
4. Round-robin fairness:
   - Stimulus: both requesters re-assert immediately after every r pulse, for 6 accesses.
   - Required: grant sequence 0,1,0,1,0,1; no requester starved.
5. Input change mid-access:
   - Stimulus: change cpu_addr from 16'h3000 to 16'h4000 and drop cpu_req during ACCESS.
   - Required: mem_addr stays 16'h3000; cpu_r still pulses.
6. Async reset mid-access:
   - Stimulus: rst asserted between clock edges during ACCESS.
   - Required: mem_en, busy and grant go to 0 before the next edge; no r pulse; after release, the first tie goes to the CPU.
